// File: rtl/clock_dp_pkg.sv
// Shared definitions for the digital clock datapath: ALU op codes,
// time/date register map and controller state encoding.
package clock_dp_pkg;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

    localparam logic [3:0] R_SEC   = 4'd0;
    localparam logic [3:0] R_MIN   = 4'd1;
    localparam logic [3:0] R_HOUR  = 4'd2;
    localparam logic [3:0] R_DAY   = 4'd3;
    localparam logic [3:0] R_MON   = 4'd4;
    localparam logic [3:0] R_YEAR  = 4'd5;
    localparam logic [3:0] R_AMIN  = 4'd6;
    localparam logic [3:0] R_AHOUR = 4'd7;

    typedef enum logic {
        INIT,
        RUN
    } state_t;

endpackage

// File: rtl/dp_alu.sv
// Combinational W-bit ALU: add, add-with-inverted-B (subtract), and, or.
module dp_alu
    import clock_dp_pkg::*;
#(
    parameter int W = 6
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [1:0]   s,
    input  logic         cin,
    output logic [W-1:0] y,
    output logic         co
);

    logic [W:0] sum;

    // Select the operation; the extra top bit of sum is the carry out.
    always_comb begin
        sum = '0;
        case (s)
            ALU_ADD: sum = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
            ALU_SUB: sum = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, cin};
            ALU_AND: sum = {1'b0, a & b};
            default: sum = {1'b0, a | b};
        endcase
        y  = sum[W-1:0];
        co = sum[W];
    end

endmodule

// File: rtl/clock_datapath.sv
// Datapath responder for the digital clock controllers: bus, A/B operands,
// time/date register file, ALU flags, alarm match and the update tick.
module clock_datapath
    import clock_dp_pkg::*;
#(
    parameter int W    = 6,
    parameter int DIV  = 1000,
    parameter int NREG = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cw_valid,
    output logic         cw_ready,
    input  logic         la,
    input  logic         lb,
    input  logic         lr,
    input  logic         er,
    input  logic         ea,
    input  logic         ealu,
    input  logic         kc,
    input  logic [1:0]   s,
    input  logic         cin,
    input  logic [3:0]   t,
    input  logic         clr,
    output logic [W-1:0] databus,
    output logic [W-1:0] a_q,
    output logic [W-1:0] b_q,
    output logic         az,
    output logic         c7,
    output logic         match,
    output logic         u_req,
    input  logic         u_ack,
    output logic         u_miss,
    output logic         bus_err
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IW = $clog2(NREG);

    state_t         state, state_d;
    logic [IW-1:0]  idx, idx_d;
    logic [W-1:0]   rf [NREG];
    logic           accept;
    logic [2:0]     n_drv;
    logic [W-1:0]   bus_d;
    logic [W-1:0]   alu_y;
    logic           alu_co;
    logic [CW-1:0]  cnt;
    logic           wrap;

    assign cw_ready = (state == RUN);
    assign accept   = cw_valid & cw_ready;
    assign n_drv    = 3'(er) + 3'(ea) + 3'(ealu) + 3'(kc);
    assign wrap     = (cnt == CW'(DIV - 1));
    assign databus  = bus_d;

    dp_alu #(.W(W)) u_alu (
        .a   (a_q),
        .b   (b_q),
        .s   (s),
        .cin (cin),
        .y   (alu_y),
        .co  (alu_co)
    );

    // Bus driver selection with fixed priority er > ea > ealu > kc.
    always_comb begin
        bus_d = '0;
        if (accept) begin
            if (er)        bus_d = rf[t];
            else if (ea)   bus_d = a_q;
            else if (ealu) bus_d = alu_y;
            else if (kc)   bus_d = W'(t);
        end
    end

    // Next state: INIT walks idx across the register file, clr restarts it.
    always_comb begin
        state_d = state;
        idx_d   = idx;
        case (state)
            INIT: begin
                if (clr) begin
                    idx_d = '0;
                end else if (idx == IW'(NREG - 1)) begin
                    state_d = RUN;
                    idx_d   = '0;
                end else begin
                    idx_d = idx + 1'b1;
                end
            end
            RUN: begin
                if (clr) begin
                    state_d = INIT;
                    idx_d   = '0;
                end
            end
            default: begin
                state_d = INIT;
                idx_d   = '0;
            end
        endcase
    end

    // Controller state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= INIT;
            idx   <= '0;
        end else begin
            state <= state_d;
            idx   <= idx_d;
        end
    end

    // Register file: not reset, cleared by the INIT walk, loaded from the bus.
    always_ff @(posedge clk) begin
        if (state == INIT)
            rf[idx] <= '0;
        else if (accept && lr)
            rf[t] <= bus_d;
    end

    // Operand registers, ALU flags, bus conflict pulse and alarm compare.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            az      <= 1'b0;
            c7      <= 1'b0;
            bus_err <= 1'b0;
            match   <= 1'b0;
        end else begin
            if (accept && la) a_q <= bus_d;
            if (accept && lb) b_q <= bus_d;
            if (accept && ealu) begin
                az <= (alu_y == '0);
                c7 <= alu_co;
            end
            bus_err <= accept && (n_drv > 3'd1);
            match   <= (rf[R_MIN] == rf[R_AMIN]) && (rf[R_HOUR] == rf[R_AHOUR]);
        end
    end

    // Update tick: a wrap always (re)asserts u_req and wins over an ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            u_req  <= 1'b0;
            u_miss <= 1'b0;
        end else begin
            cnt    <= wrap ? '0 : cnt + 1'b1;
            u_miss <= wrap && u_req && !u_ack;
            if (wrap)
                u_req <= 1'b1;
            else if (u_ack && u_req)
                u_req <= 1'b0;
        end
    end

endmodule

// File: tb/tb_clock_datapath.sv
// Bench for clock_datapath: directed vector table, randomized control words
// against a behavioural model, clear/restart and update-tick sequences.
module tb_clock_datapath;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cw_valid = 1'b0, la = 1'b0, lb = 1'b0, lr = 1'b0;
    logic       er = 1'b0, ea = 1'b0, ealu = 1'b0, kc = 1'b0;
    logic [1:0] s = '0;
    logic       cin = 1'b0, clr = 1'b0, u_ack = 1'b0;
    logic [3:0] t = '0;
    logic       cw_ready, az, c7, match, u_req, u_miss, bus_err;
    logic [5:0] databus, a_q, b_q;

    logic       rst2_n = 1'b0, u_ack2 = 1'b0;
    logic       z1 = 1'b0;
    logic [1:0] z2 = '0;
    logic [3:0] z4 = '0;
    logic       cw_ready2, az2, c72, match2, u_req2, u_miss2, bus_err2;
    logic [5:0] databus2, a_q2, b_q2;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    clock_datapath #(.W(6), .DIV(1000), .NREG(16)) dut (
        .clk(clk), .rst_n(rst_n), .cw_valid(cw_valid), .cw_ready(cw_ready),
        .la(la), .lb(lb), .lr(lr), .er(er), .ea(ea), .ealu(ealu), .kc(kc),
        .s(s), .cin(cin), .t(t), .clr(clr), .databus(databus), .a_q(a_q),
        .b_q(b_q), .az(az), .c7(c7), .match(match), .u_req(u_req),
        .u_ack(u_ack), .u_miss(u_miss), .bus_err(bus_err)
    );

    clock_datapath #(.W(6), .DIV(4), .NREG(16)) dut_tick (
        .clk(clk), .rst_n(rst2_n), .cw_valid(z1), .cw_ready(cw_ready2),
        .la(z1), .lb(z1), .lr(z1), .er(z1), .ea(z1), .ealu(z1), .kc(z1),
        .s(z2), .cin(z1), .t(z4), .clr(z1), .databus(databus2), .a_q(a_q2),
        .b_q(b_q2), .az(az2), .c7(c72), .match(match2), .u_req(u_req2),
        .u_ack(u_ack2), .u_miss(u_miss2), .bus_err(bus_err2)
    );

    typedef struct {
        logic       v, la, lb, lr, er, ea, ealu, kc;
        logic [1:0] s;
        logic       cin;
        logic [3:0] t;
        logic [5:0] e_bus, e_a, e_b;
        logic       e_az, e_c7, e_err;
    } vec_t;

    // Behavioural model state
    int m_a = 0, m_b = 0, m_az = 0, m_c7 = 0;
    int m_rf [16];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void ref_alu(input int a, input int b, input int op, input int ci,
                                    output int y, output int co);
        int r;
        case (op)
            0:       r = a + b + ci;
            1:       r = a + (63 - b) + ci;
            2:       r = a & b;
            default: r = a | b;
        endcase
        y  = r % 64;
        co = r / 64;
    endfunction

    // One control-word cycle; entered and left at posedge+1.
    task automatic exec(input vec_t c, input bit use_tab);
        int mb, y, co, nd, e_err, e_match;
        cw_valid = c.v; la = c.la; lb = c.lb; lr = c.lr; er = c.er; ea = c.ea;
        ealu = c.ealu; kc = c.kc; s = c.s; cin = c.cin; t = c.t;
        ref_alu(m_a, m_b, int'(c.s), int'(c.cin), y, co);
        if (!c.v)         mb = 0;
        else if (c.er)    mb = m_rf[c.t];
        else if (c.ea)    mb = m_a;
        else if (c.ealu)  mb = y;
        else if (c.kc)    mb = int'(c.t);
        else              mb = 0;
        nd      = int'(c.er) + int'(c.ea) + int'(c.ealu) + int'(c.kc);
        e_err   = (c.v && nd > 1) ? 1 : 0;
        e_match = (m_rf[1] == m_rf[6] && m_rf[2] == m_rf[7]) ? 1 : 0;
        @(negedge clk);
        chk("bus", int'(databus), mb);
        if (use_tab) chk("tab_bus", int'(databus), int'(c.e_bus));
        if (c.v) begin
            if (c.la) m_a = mb;
            if (c.lb) m_b = mb;
            if (c.lr) m_rf[c.t] = mb;
            if (c.ealu) begin
                m_az = (y == 0) ? 1 : 0;
                m_c7 = co;
            end
        end
        @(posedge clk); #1;
        chk("a_q", int'(a_q), m_a);
        chk("b_q", int'(b_q), m_b);
        chk("az", int'(az), m_az);
        chk("c7", int'(c7), m_c7);
        chk("bus_err", int'(bus_err), e_err);
        chk("match", int'(match), e_match);
        if (use_tab) begin
            chk("tab_a", int'(a_q), int'(c.e_a));
            chk("tab_b", int'(b_q), int'(c.e_b));
            chk("tab_az", int'(az), int'(c.e_az));
            chk("tab_c7", int'(c7), int'(c.e_c7));
            chk("tab_err", int'(bus_err), int'(c.e_err));
        end
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (!cw_ready && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk(name, n, 16);
    endtask

    vec_t tab [24];
    vec_t rv;

    initial begin
        int req, wrp, ack, miss;
        for (int unsigned i = 0; i < 16; i++) m_rf[i] = 0;

        //  v la lb lr er ea alu kc  s  cin t    bus a  b  az c7 err
        tab[0]  = '{1,1,0,0,0,0,0,1, 0,0, 9,   9, 9, 0, 0,0,0};
        tab[1]  = '{1,0,1,0,0,0,0,1, 0,0, 6,   6, 9, 6, 0,0,0};
        tab[2]  = '{1,0,0,1,0,0,1,0, 0,0, 0,  15, 9, 6, 0,0,0};
        tab[3]  = '{1,0,0,0,1,0,0,0, 0,0, 0,  15, 9, 6, 0,0,0};
        tab[4]  = '{1,0,1,0,0,0,0,1, 0,0, 9,   9, 9, 9, 0,0,0};
        tab[5]  = '{1,0,0,0,0,0,1,0, 1,1, 0,   0, 9, 9, 1,1,0};
        tab[6]  = '{1,1,0,0,0,0,0,1, 0,0, 5,   5, 5, 9, 1,1,0};
        tab[7]  = '{1,0,0,0,0,0,1,0, 1,1, 0,  60, 5, 9, 0,0,0};
        tab[8]  = '{1,1,0,0,0,0,0,1, 0,0,15,  15,15, 9, 0,0,0};
        tab[9]  = '{1,0,1,0,0,0,0,1, 0,0,15,  15,15,15, 0,0,0};
        tab[10] = '{1,1,0,0,0,0,1,0, 0,0, 0,  30,30,15, 0,0,0};
        tab[11] = '{1,1,0,0,0,0,1,0, 0,0, 0,  45,45,15, 0,0,0};
        tab[12] = '{1,1,0,0,0,0,1,0, 0,0, 0,  60,60,15, 0,0,0};
        tab[13] = '{1,1,0,0,0,0,1,0, 3,0, 0,  63,63,15, 0,0,0};
        tab[14] = '{1,0,1,0,0,0,0,1, 0,0, 1,   1,63, 1, 0,0,0};
        tab[15] = '{1,0,0,0,0,0,1,0, 0,0, 0,   0,63, 1, 1,1,0};
        tab[16] = '{1,1,0,0,0,1,0,0, 0,0, 0,  63,63, 1, 1,1,0};
        tab[17] = '{1,0,0,0,0,0,1,0, 2,0, 0,   1,63, 1, 0,0,0};
        tab[18] = '{1,0,0,0,1,0,0,1, 0,0, 0,  15,63, 1, 0,0,1};
        tab[19] = '{0,1,0,0,0,0,0,1, 0,0, 3,   0,63, 1, 0,0,0};
        tab[20] = '{1,0,0,1,1,0,0,0, 0,0, 0,  15,63, 1, 0,0,0};
        tab[21] = '{1,0,0,0,1,0,0,0, 0,0, 0,  15,63, 1, 0,0,0};
        tab[22] = '{1,0,0,0,0,1,1,0, 0,0, 0,  63,63, 1, 1,1,1};
        tab[23] = '{1,0,0,0,0,0,0,0, 0,0, 0,   0,63, 1, 1,1,0};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", int'(cw_ready), 0);
        chk("rst_a", int'(a_q), 0);
        chk("rst_b", int'(b_q), 0);
        chk("rst_az", int'(az), 0);
        chk("rst_c7", int'(c7), 0);
        chk("rst_ureq", int'(u_req), 0);
        chk("rst_berr", int'(bus_err), 0);
        rst_n = 1'b1;
        wait_ready("init_cycles");

        // All entries cleared by INIT
        for (int unsigned i = 0; i < 16; i++) begin
            rv = '{1,0,0,0,1,0,0,0, 0,0, 4'(i), 0,0,0, 0,0,0};
            exec(rv, 1'b0);
        end
        chk("match_all_zero", int'(match), 1);

        // Directed vectors
        for (int unsigned i = 0; i < 24; i++) exec(tab[i], 1'b1);

        // Randomized control words against the model
        for (int unsigned i = 0; i < 400; i++) begin
            rv.v    = ($urandom_range(0, 7) != 0);
            rv.la   = ($urandom_range(0, 2) == 0);
            rv.lb   = ($urandom_range(0, 2) == 0);
            rv.lr   = ($urandom_range(0, 2) == 0);
            rv.er   = ($urandom_range(0, 3) == 0);
            rv.ea   = ($urandom_range(0, 4) == 0);
            rv.ealu = ($urandom_range(0, 2) == 0);
            rv.kc   = ($urandom_range(0, 2) == 0);
            rv.s    = 2'($urandom_range(0, 3));
            rv.cin  = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 7))
                0:       rv.t = 4'd1;
                1:       rv.t = 4'd2;
                2:       rv.t = 4'd6;
                3:       rv.t = 4'd7;
                default: rv.t = 4'($urandom_range(0, 15));
            endcase
            exec(rv, 1'b0);
        end

        // clr in RUN: the word in that cycle still executes, then a full INIT
        cw_valid = 1; la = 1; kc = 1; t = 4'd3; clr = 1;
        lb = 0; lr = 0; er = 0; ea = 0; ealu = 0;
        @(posedge clk); #1;
        cw_valid = 0; la = 0; kc = 0; clr = 0;
        m_a = 3;
        chk("clr_a", int'(a_q), 3);
        chk("clr_ready", int'(cw_ready), 0);
        wait_ready("clr_init_cycles");
        for (int unsigned i = 0; i < 16; i++) m_rf[i] = 0;

        // clr during INIT restarts the walk
        cw_valid = 1; clr = 1;
        @(posedge clk); #1;
        cw_valid = 0; clr = 0;
        repeat (5) @(posedge clk);
        #1;
        clr = 1;
        @(posedge clk); #1;
        clr = 0;
        wait_ready("clr_restart_cycles");
        for (int unsigned i = 0; i < 16; i++) begin
            rv = '{1,0,0,0,1,0,0,0, 0,0, 4'(i), 0,0,0, 0,0,0};
            exec(rv, 1'b0);
        end

        // Update tick on the DIV=4 instance
        chk("tick_rst_req", int'(u_req2), 0);
        chk("tick_rst_miss", int'(u_miss2), 0);
        rst2_n = 1'b1;
        req = 0;
        for (int k = 1; k <= 18; k++) begin
            ack = (k == 10 || k == 16) ? 1 : 0;
            u_ack2 = ack[0];
            @(posedge clk); #1;
            wrp  = (k % 4 == 0) ? 1 : 0;
            miss = (wrp && req && !ack) ? 1 : 0;
            if (wrp) req = 1;
            else if (ack && req) req = 0;
            chk($sformatf("u_req_%0d", k), int'(u_req2), req);
            chk($sformatf("u_miss_%0d", k), int'(u_miss2), miss);
        end
        u_ack2 = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
